dbus_uart_tx: RTL

DBUS_UART_TX -- requirements
Module: dbus_uart_tx

---
 rtl/dbus_uart_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dbus_uart_tx.sv
// DBUS link endpoint to 8N1 UART transmitter.
// A fetch FSM fills a small FIFO that the serialiser drains.
module dbus_uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        i_avail,
  input  logic [7:0]                  i_data,
  output logic                        o_read,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic {
    F_IDLE,
    F_HOLD
  } fstate_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tstate_e;

  fstate_e       fstate_q;
  tstate_e       tstate_q;
  logic          read_q;
  logic          tx_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          push;
  logic          pop;
  logic          have_data;
  logic          baud_end;

  // The byte is written on the edge that closes the o_read cycle;
  // the endpoint still holds it there.
  assign push      = read_q;
  assign have_data = (count_q != '0);
  assign baud_end  = (baud_q == BAUD_LAST);
  assign pop       = have_data &&
                     ((tstate_q == S_IDLE) ||
                      ((tstate_q == S_STOP) && baud_end));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fstate_q <= F_IDLE;
      read_q   <= 1'b0;
    end else begin
      read_q <= 1'b0;
      unique case (fstate_q)
        F_IDLE: begin
          if (i_avail && (count_q < FULL)) begin
            read_q   <= 1'b1;
            fstate_q <= F_HOLD;
          end
        end
        F_HOLD: begin
          if (!i_avail) fstate_q <= F_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  // o_tx is a flop that follows the state one cycle later,
  // so every bit still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tstate_q <= S_IDLE;
      tx_q     <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      baud_q <= baud_end ? '0 : baud_q + BW'(1);
      unique case (tstate_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          bit_q  <= '0;
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            tstate_q <= S_START;
          end
        end
        S_START: begin
          tx_q  <= 1'b0;
          bit_q <= '0;
          if (baud_end) tstate_q <= S_DATA;
        end
        S_DATA: begin
          tx_q <= shift_q[0];
          if (baud_end) begin
            shift_q <= shift_q >> 1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) tstate_q <= S_STOP;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (baud_end) begin
            if (pop) begin
              shift_q  <= mem_q[rd_ptr_q];
              tstate_q <= S_START;
            end else begin
              tstate_q <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign o_read  = read_q;
  assign o_tx    = tx_q;
  assign o_busy  = have_data || (tstate_q != S_IDLE);
  assign o_count = count_q;

endmodule
